sram_bank_arb: RTL and testbench
================================

Name: sram_bank_arb

Overview:
Single-port SRAM bank shared by CHANNEL requestors through an internal arbiter. This is the parametrised successor to the static-select bank mux. It provides:
- per-channel valid/ready request handshake
- round-robin or fixed-priority arbitration
- byte-enable writes
- configurable read latency, with per-channel response valid routed back to the winning requestor
- a saturating conflict counter for performance monitoring

It sits between the vector-cache channel logic and the data SRAM banks.

Parameters:
CHANNEL, 8, number of requesting channels (2..16)
MEM_WIDTH, 32, data width in bits (multiple of 8)
MEM_DEPTH, 2048, words per bank
RD_LATENCY, 1, cycles from read acceptance to response (1..4)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
CNT_WIDTH, 16, conflict counter width
SEL_WIDTH, $clog2(CHANNEL), channel index width (derived)
ADDR_WIDTH, $clog2(MEM_DEPTH), word address width (derived)
BE_WIDTH, MEM_WIDTH/8, byte-enable width (derived)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active-high (1 = in reset)
req_vld  in  CHANNEL  per-channel request valid
req_rdy  out  CHANNEL  per-channel grant/ready, one-hot or zero
req_wr  in  CHANNEL  per-channel op: 1 = write, 0 = read
req_addr  in  ADDR_WIDTH x CHANNEL  per-channel word address
req_wdata  in  MEM_WIDTH x CHANNEL  per-channel write data
req_be  in  BE_WIDTH x CHANNEL  per-channel byte enables
rsp_vld  out  CHANNEL  per-channel read response valid, at most one bit set
rsp_rdata  out  MEM_WIDTH  read data, valid when any rsp_vld bit is set
rsp_ch  out  SEL_WIDTH  channel index of the current response
cnt_clr  in  1  synchronous clear of conflict_cnt
conflict_cnt  out  CNT_WIDTH  saturating count of cycles with two or more req_vld set

Behaviour:
Reset:
- ptr = 0; read pipeline valids = 0.
- rsp_vld = 0, rsp_rdata = 0, rsp_ch = 0, conflict_cnt = 0.
- Memory contents are not reset.
- Reads in flight when reset asserts are dropped; no rsp_vld after reset releases.

Arbitration (combinational from req_vld and ptr):
- req_rdy has exactly one bit set when any req_vld is set, else it is 0.
- RR mode: the first set req_vld searching from index ptr upward, with wrap-around modulo CHANNEL.
- Fixed mode: lowest set index; ptr is unused.
- req_rdy depends on req_vld. Requestors must not make req_vld depend on req_rdy.
- A requestor holds req_vld and its payload stable until req_rdy is seen.

Accept:
- accept = |(req_vld & req_rdy); g = index of the granted channel.
- RR mode: ptr <= (g+1) mod CHANNEL on accept; ptr is unchanged with no accept.

Write accept:
- mem[addr][8b+7:8b] <= wdata byte b for every b where be[b] = 1. Other bytes are unchanged.
- be = 0 is a legal no-op write.
- No response is generated.

Read accept:
- Memory is read at the accept edge.
- The data passes through a RD_LATENCY-1 stage pipeline of {vld, ch, data}.
- rsp_vld[g] = 1 exactly RD_LATENCY cycles after the accept edge, for one cycle, with rsp_rdata and rsp_ch = g.
- No backpressure on responses; the consumer must always accept.

Hazards:
- Read in the cycle after a write to the same address returns the new data.
- Read and write cannot be simultaneous (single grant per cycle).

Throughput:
- One accept per cycle.
- Back-to-back reads from different channels produce back-to-back rsp_vld in the same order.

Idle cycles:
- rsp_rdata holds its last value; rsp_vld = 0.

conflict_cnt:
- Increments when popcount(req_vld) >= 2.
- Saturates at all-ones.
- cnt_clr has priority: clears to 0 that cycle, no increment.

Test Plan:
- RR fairness: CHANNEL=8, req_vld = 0xFF held, all reads -> grants in order 0,1,…,7,0. One rsp_vld per cycle starting RD_LATENCY after the first grant. conflict_cnt = 8 after 8 cycles.
- Byte enables: write 0x11223344 to addr 5 with be=0xF, then 0xAABBCCDD with be=0x5, then read addr 5 -> rsp_rdata = 0x11BB33DD on the requesting channel's rsp_vld.
- Latency sweep RD_LATENCY = 1..4: ch3 read of addr 0x7FF (preloaded 0xDEADBEEF) -> rsp_vld[3] = 1 exactly N cycles after the accept edge, rsp_ch = 3.
- Fixed priority: ARB_MODE=1, req_vld = 0b1010 held for 3 cycles -> ch1 granted every cycle, ch3 starved. Drop ch1 -> ch3 granted next cycle.
- Write-then-read: ch0 writes 0x5A5A5A5A to addr 9, next cycle ch2 reads addr 9 -> rsp_rdata = 0x5A5A5A5A.
- Reset mid-read: RD_LATENCY=3, assert rst_n one cycle after a read accept -> all outputs 0 immediately. No rsp_vld after release. ptr = 0, so the next RR grant with req_vld = 0xFF is ch0. conflict_cnt with CNT_WIDTH=4 saturates at 15 under sustained conflict, and clears on cnt_clr.

Source files
------------

// File: rtl/sram_bank_arb.sv
// Single-port SRAM bank shared by CHANNEL requestors through a round-robin or
// fixed-priority arbiter, with byte-enable writes and a fixed-latency read return path.
module sram_bank_arb #(
    parameter int CHANNEL    = 8,
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 2048,
    parameter int RD_LATENCY = 1,
    parameter int ARB_MODE   = 0,
    parameter int CNT_WIDTH  = 16,
    localparam int SEL_WIDTH  = $clog2(CHANNEL),
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int BE_WIDTH   = MEM_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNEL-1:0]            req_vld,
    output logic [CHANNEL-1:0]            req_rdy,
    input  logic [CHANNEL-1:0]            req_wr,
    input  logic [CHANNEL*ADDR_WIDTH-1:0] req_addr,
    input  logic [CHANNEL*MEM_WIDTH-1:0]  req_wdata,
    input  logic [CHANNEL*BE_WIDTH-1:0]   req_be,
    output logic [CHANNEL-1:0]            rsp_vld,
    output logic [MEM_WIDTH-1:0]          rsp_rdata,
    output logic [SEL_WIDTH-1:0]          rsp_ch,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          conflict_cnt
);

    // rst_n is active-high despite its name; alias it so the logic reads naturally.
    logic in_rst;
    assign in_rst = rst_n;

    logic [ADDR_WIDTH-1:0] addr_arr  [CHANNEL];
    logic [MEM_WIDTH-1:0]  wdata_arr [CHANNEL];
    logic [BE_WIDTH-1:0]   be_arr    [CHANNEL];

    generate
        for (genvar gi = 0; gi < CHANNEL; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*MEM_WIDTH +: MEM_WIDTH];
            assign be_arr[gi]    = req_be[gi*BE_WIDTH +: BE_WIDTH];
        end
    endgenerate

    logic [SEL_WIDTH-1:0] ptr_q;
    logic [SEL_WIDTH-1:0] ptr_d;
    logic [SEL_WIDTH-1:0] start_idx;
    logic [SEL_WIDTH-1:0] gnt_idx;
    logic [SEL_WIDTH:0]   probe;
    logic                 gnt_any;

    // Fixed priority is round-robin with the search origin pinned at channel 0.
    always_comb begin
        start_idx = (ARB_MODE == 1) ? '0 : ptr_q;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        probe     = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            probe = {1'b0, start_idx} + (SEL_WIDTH+1)'(i);
            if (probe >= (SEL_WIDTH+1)'(CHANNEL)) begin
                probe = probe - (SEL_WIDTH+1)'(CHANNEL);
            end
            if (!gnt_any && req_vld[probe[SEL_WIDTH-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = probe[SEL_WIDTH-1:0];
            end
        end
    end

    logic accept;
    logic wr_en;
    logic rd_en;
    assign accept = gnt_any && !in_rst;
    assign wr_en  = accept && req_wr[gnt_idx];
    assign rd_en  = accept && !req_wr[gnt_idx];

    always_comb begin
        req_rdy = '0;
        if (accept) begin
            req_rdy[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && ARB_MODE == 0) begin
            ptr_d = (gnt_idx == SEL_WIDTH'(CHANNEL - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Storage and its read register carry no reset so they map onto block RAM.
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be_arr[gnt_idx][b]) begin
                    mem[addr_arr[gnt_idx]][b*8 +: 8] <= wdata_arr[gnt_idx][b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[addr_arr[gnt_idx]];
        end
    end

    logic                 pvld_q [RD_LATENCY];
    logic [SEL_WIDTH-1:0] pch_q  [RD_LATENCY];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                pvld_q[s] <= 1'b0;
                pch_q[s]  <= '0;
            end
        end else begin
            pvld_q[0] <= rd_en;
            if (rd_en) begin
                pch_q[0] <= gnt_idx;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                pvld_q[s] <= pvld_q[s-1];
                if (pvld_q[s-1]) begin
                    pch_q[s] <= pch_q[s-1];
                end
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // The raw RAM register is not reset, so mask it until the first read lands.
            logic seen_q;
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    seen_q <= 1'b0;
                end else if (rd_en) begin
                    seen_q <= 1'b1;
                end
            end
            assign rsp_rdata = seen_q ? rd_data_q : '0;
        end else begin : g_latn
            logic [MEM_WIDTH-1:0] pdat_q [1:RD_LATENCY-1];
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    for (int s = 1; s < RD_LATENCY; s++) begin
                        pdat_q[s] <= '0;
                    end
                end else begin
                    if (pvld_q[0]) begin
                        pdat_q[1] <= rd_data_q;
                    end
                    for (int s = 2; s < RD_LATENCY; s++) begin
                        if (pvld_q[s-1]) begin
                            pdat_q[s] <= pdat_q[s-1];
                        end
                    end
                end
            end
            assign rsp_rdata = pdat_q[RD_LATENCY-1];
        end
    endgenerate

    always_comb begin
        rsp_vld = '0;
        if (pvld_q[RD_LATENCY-1]) begin
            rsp_vld[pch_q[RD_LATENCY-1]] = 1'b1;
        end
    end
    assign rsp_ch = pch_q[RD_LATENCY-1];

    // Two or more valids <=> clearing the lowest set bit leaves something behind.
    logic                 multi_req;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    assign multi_req = |(req_vld & (req_vld - 1'b1));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (multi_req && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    assign conflict_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_bank_arb.sv
// Bench for sram_bank_arb: a round-robin, latency-3 bank against a queue/array model,
// plus a fixed-priority, latency-1 bank driven from a vector table.
module tb_sram_bank_arb;

    localparam int LAT_A = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Bank A: 8 channels, round-robin, read latency 3, 4-bit conflict counter
    logic [7:0]    a_vld, a_rdy, a_wr, a_rsp_vld;
    logic [87:0]   a_addr;
    logic [255:0]  a_wdata;
    logic [31:0]   a_be;
    logic [31:0]   a_rdata;
    logic [2:0]    a_rsp_ch;
    logic          a_cnt_clr;
    logic [3:0]    a_cnt;

    // Bank B: 4 channels, fixed priority, read latency 1
    logic [3:0]    b_vld, b_rdy, b_wr, b_rsp_vld;
    logic [43:0]   b_addr;
    logic [127:0]  b_wdata;
    logic [15:0]   b_be;
    logic [31:0]   b_rdata;
    logic [1:0]    b_rsp_ch;
    logic          b_cnt_clr;
    logic [15:0]   b_cnt;

    sram_bank_arb #(.CHANNEL(8), .MEM_WIDTH(32), .MEM_DEPTH(2048), .RD_LATENCY(LAT_A),
                    .ARB_MODE(0), .CNT_WIDTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .req_vld(a_vld), .req_rdy(a_rdy), .req_wr(a_wr),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .rsp_vld(a_rsp_vld),
        .rsp_rdata(a_rdata), .rsp_ch(a_rsp_ch), .cnt_clr(a_cnt_clr), .conflict_cnt(a_cnt));

    sram_bank_arb #(.CHANNEL(4), .MEM_WIDTH(32), .MEM_DEPTH(2048), .RD_LATENCY(1),
                    .ARB_MODE(1), .CNT_WIDTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .req_vld(b_vld), .req_rdy(b_rdy), .req_wr(b_wr),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_vld(b_rsp_vld),
        .rsp_rdata(b_rdata), .rsp_ch(b_rsp_ch), .cnt_clr(b_cnt_clr), .conflict_cnt(b_cnt));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model of bank A
    typedef struct { bit vld; bit wr; logic [10:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;
    typedef struct { int due; int ch; logic [31:0] data; } rsp_t;
    typedef struct { logic [3:0] vld; logic [3:0] rdy; } bvec_t;

    req_t        pend [8];
    logic [31:0] m_mem [int];
    rsp_t        m_q [$];
    int          m_ptr, m_cnt, cyc, acc_cyc, obs_cyc, obs_ch;
    logic [31:0] m_last, obs_data;

    function automatic int model_grant(input logic [7:0] v, input int ptr);
        for (int k = 0; k < 8; k++) begin
            if (v[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic apply_a();
        for (int c = 0; c < 8; c++) begin
            a_vld[c]            = pend[c].vld;
            a_wr[c]             = pend[c].wr;
            a_addr[c*11 +: 11]  = pend[c].addr;
            a_wdata[c*32 +: 32] = pend[c].wdata;
            a_be[c*4 +: 4]      = pend[c].be;
        end
    endtask

    task automatic set_req(input int c, input bit wr, input logic [10:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        pend[c] = '{vld: 1'b1, wr: wr, addr: addr, wdata: wdata, be: be};
    endtask

    // One clock of bank A: drive, check at the falling edge, then advance the model.
    task automatic run_a(output int g_dut);
        logic [7:0]  v;
        logic [31:0] word;
        rsp_t        r;
        int          g;
        for (int c = 0; c < 8; c++) v[c] = pend[c].vld;
        apply_a();
        @(negedge clk);
        g = model_grant(v, m_ptr);
        chk("a_rdy", a_rdy, (g < 0) ? 64'd0 : (64'd1 << g));
        g_dut = -1;
        for (int c = 0; c < 8; c++) if (a_rdy[c]) g_dut = c;
        if (a_rsp_vld != 0) begin
            obs_cyc  = cyc;
            obs_data = a_rdata;
            obs_ch   = int'(a_rsp_ch);
        end
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            r = m_q.pop_front();
            chk("a_rsp_vld", a_rsp_vld, 64'd1 << r.ch);
            chk("a_rsp_rdata", a_rdata, r.data);
            chk("a_rsp_ch", a_rsp_ch, r.ch);
            m_last = r.data;
        end else begin
            chk("a_rsp_idle", a_rsp_vld, 0);
            chk("a_rdata_hold", a_rdata, m_last);
        end
        chk("a_conflict_cnt", a_cnt, m_cnt);
        if (g >= 0) begin
            word = m_mem.exists(int'(pend[g].addr)) ? m_mem[int'(pend[g].addr)] : 32'h0;
            if (pend[g].wr) begin
                for (int b = 0; b < 4; b++)
                    if (pend[g].be[b]) word[b*8 +: 8] = pend[g].wdata[b*8 +: 8];
                m_mem[int'(pend[g].addr)] = word;
            end else begin
                m_q.push_back('{due: cyc + LAT_A, ch: g, data: word});
            end
            $display("txn cyc=%0d ch=%0d %s addr=0x%0h wdata=0x%0h be=0x%0h",
                     cyc, g, pend[g].wr ? "WR" : "RD", pend[g].addr, pend[g].wdata, pend[g].be);
            acc_cyc     = cyc;
            m_ptr       = (g + 1) % 8;
            pend[g].vld = 1'b0;
        end
        if (a_cnt_clr) m_cnt = 0;
        else if ($countones(v) >= 2 && m_cnt < 15) m_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int n);
        int g;
        for (int i = 0; i < n; i++) run_a(g);
    endtask

    task automatic do_reset();
        for (int c = 0; c < 8; c++) pend[c].vld = 1'b0;
        apply_a();
        rst_n = 1'b1;
        #1;
        chk("rst_rsp_vld", a_rsp_vld, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_rsp_ch", a_rsp_ch, 0);
        chk("rst_cnt", a_cnt, 0);
        m_q.delete();
        m_ptr  = 0;
        m_cnt  = 0;
        m_last = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    bvec_t btbl [9];
    int    exp_b_cnt;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        btbl[0] = '{4'b1010, 4'b0010};
        btbl[1] = '{4'b1010, 4'b0010};
        btbl[2] = '{4'b1010, 4'b0010};
        btbl[3] = '{4'b1000, 4'b1000};
        btbl[4] = '{4'b1111, 4'b0001};
        btbl[5] = '{4'b0110, 4'b0010};
        btbl[6] = '{4'b1100, 4'b0100};
        btbl[7] = '{4'b0000, 4'b0000};
        btbl[8] = '{4'b0001, 4'b0001};

        rst_n = 1'b1;
        a_cnt_clr = 1'b0;
        b_cnt_clr = 1'b0;
        for (int c = 0; c < 8; c++) pend[c] = '{1'b0, 1'b0, 11'h0, 32'h0, 4'h0};
        apply_a();
        b_vld = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_be = '0;
        m_ptr = 0; m_cnt = 0; m_last = '0; cyc = 0; acc_cyc = 0; obs_cyc = -1; obs_ch = -1;
        obs_data = '0;

        // Reset state, with requests present to show the grant is held off.
        a_vld = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_rdy", a_rdy, 0);
        chk("reset_a_rsp_vld", a_rsp_vld, 0);
        chk("reset_a_rdata", a_rdata, 0);
        chk("reset_a_rsp_ch", a_rsp_ch, 0);
        chk("reset_a_cnt", a_cnt, 0);
        chk("reset_b_rsp_vld", b_rsp_vld, 0);
        chk("reset_b_rdata", b_rdata, 0);
        chk("reset_b_cnt", b_cnt, 0);
        apply_a();
        rst_n = 1'b0;

        // Bank B, fixed priority: zero-byte-enable writes so nothing is returned.
        exp_b_cnt = 0;
        b_wr = 4'hF;
        for (int i = 0; i < 9; i++) begin
            b_vld = btbl[i].vld;
            @(negedge clk);
            chk("b_fixed_rdy", b_rdy, btbl[i].rdy);
            if ($countones(btbl[i].vld) >= 2) exp_b_cnt++;
            @(posedge clk);
            #1;
        end
        b_vld = '0;
        chk("b_conflict_cnt", b_cnt, exp_b_cnt);

        // Bank B latency 1: ch3 preloads 0x7FF, a be=0 write leaves it alone, then reads it.
        b_vld = 4'b1000; b_wr = 4'b1000; b_addr[43:33] = 11'h7FF;
        b_wdata[127:96] = 32'hDEADBEEF; b_be[15:12] = 4'hF;
        @(posedge clk); #1;
        b_wdata[127:96] = 32'h0; b_be[15:12] = 4'h0;
        @(posedge clk); #1;
        b_wr = 4'b0000;
        @(negedge clk);
        chk("b_rsp_not_early", b_rsp_vld, 0);
        @(posedge clk); #1;
        b_vld = '0;
        @(negedge clk);
        chk("b_lat1_vld", b_rsp_vld, 4'b1000);
        chk("b_lat1_rdata", b_rdata, 32'hDEADBEEF);
        chk("b_lat1_ch", b_rsp_ch, 3);
        @(negedge clk);
        chk("b_rsp_one_cycle", b_rsp_vld, 0);
        chk("b_rdata_hold", b_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Bank A preload: addresses 0..15 and 0x7FF.
        for (int c = 0; c < 8; c++) set_req(c, 1'b1, 11'(c), $urandom, 4'hF);
        idle_a(8);
        for (int c = 0; c < 8; c++) set_req(c, 1'b1, 11'(c + 8), $urandom, 4'hF);
        idle_a(8);
        set_req(3, 1'b1, 11'h7FF, 32'hDEADBEEF, 4'hF);
        idle_a(2);
        do_reset();

        // Round-robin fairness with every channel reading continuously.
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 8; c++) if (!pend[c].vld) set_req(c, 1'b0, 11'(c), 32'h0, 4'h0);
            run_a(g);
            if (i < 9) chk("rr_order", g, i % 8);
            if (i == 7) chk("cnt_after8", a_cnt, 8);
        end
        chk("cnt_saturated", a_cnt, 15);
        for (int c = 0; c < 8; c++) if (!pend[c].vld) set_req(c, 1'b0, 11'(c), 32'h0, 4'h0);
        a_cnt_clr = 1'b1;
        run_a(g);
        a_cnt_clr = 1'b0;
        chk("cnt_clr_priority", a_cnt, 0);
        idle_a(12);

        // Byte enables
        set_req(0, 1'b1, 11'd5, 32'h11223344, 4'hF); idle_a(1);
        set_req(0, 1'b1, 11'd5, 32'hAABBCCDD, 4'h5); idle_a(1);
        set_req(4, 1'b0, 11'd5, 32'h0, 4'h0);        idle_a(5);
        chk("be_merge", obs_data, 32'h11BB33DD);
        chk("be_rsp_ch", obs_ch, 4);

        // Read in the cycle after a write to the same address
        set_req(0, 1'b1, 11'd9, 32'h5A5A5A5A, 4'hF); idle_a(1);
        set_req(2, 1'b0, 11'd9, 32'h0, 4'h0);        idle_a(5);
        chk("wr_then_rd", obs_data, 32'h5A5A5A5A);
        chk("wr_then_rd_ch", obs_ch, 2);

        // Read latency on channel 3
        obs_cyc = -1;
        set_req(3, 1'b0, 11'h7FF, 32'h0, 4'h0); idle_a(6);
        chk("lat3_cycles", obs_cyc - acc_cyc, LAT_A);
        chk("lat3_rdata", obs_data, 32'hDEADBEEF);
        chk("lat3_ch", obs_ch, 3);

        // Randomized traffic; requestors hold until granted.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 8; c++) begin
                if (!pend[c].vld && $urandom_range(0, 9) < 4)
                    set_req(c, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), $urandom,
                            4'($urandom_range(0, 15)));
            end
            a_cnt_clr = ($urandom_range(0, 19) == 0);
            run_a(g);
        end
        a_cnt_clr = 1'b0;
        idle_a(16);

        // Reset one cycle after a read accept on ch5 (pointer left at 6).
        set_req(5, 1'b0, 11'd3, 32'h0, 4'h0);
        idle_a(1);
        do_reset();
        idle_a(6);
        for (int c = 0; c < 8; c++) set_req(c, 1'b0, 11'(c), 32'h0, 4'h0);
        run_a(g);
        chk("rst_ptr_grant", g, 0);
        idle_a(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
